state_dump_unit: RTL and testbench

- Synthesizable successor to the simulation-only register/CSR/memory dump flow.
- On a trigger (manual pulse or periodic timer), walks the GPR file, a parametrised CSR range and a parametrised data-memory window through a shared 1-cycle-latency read port.
- Streams each word as a tagged beat over a valid/ready interface toward a UART/debug transport.
- Sits beside the pipeline data path; never stalls the core.

---
 rtl/state_dump_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_state_dump_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// state_dump_unit: on a manual or periodic trigger, walks the GPR file, a CSR
// range and a data-memory window through a shared 1-cycle read port and streams
// every word as a tagged beat over a valid/ready interface. Runs beside the
// pipeline and never stalls it.
module state_dump_unit #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned N_GPR         = 32,
    parameter int unsigned N_CSR         = 69,
    parameter logic [63:0] MEM_BASE      = 64'h0,
    parameter int unsigned MEM_WORDS     = 32,
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_trig,
    output logic            o_rd_en,
    output logic [1:0]      o_rd_sel,
    output logic [XLEN-1:0] o_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    output logic            o_dump_valid,
    input  logic            i_dump_ready,
    output logic [XLEN-1:0] o_dump_data,
    output logic [17:0]     o_dump_tag,
    output logic            o_dump_last,
    output logic            o_busy,
    output logic [7:0]      o_missed
);

    localparam int unsigned IDX_W  = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned MISS_W = 8;
    localparam int unsigned STRIDE = XLEN / 8;

    localparam logic [1:0] REG_HDR = 2'd0;
    localparam logic [1:0] REG_GPR = 2'd1;
    localparam logic [1:0] REG_CSR = 2'd2;
    localparam logic [1:0] REG_MEM = 2'd3;

    // First and final non-empty regions; HDR alone when every region is empty.
    localparam logic [1:0] FIRST_REG = (N_GPR > 0)     ? REG_GPR :
                                       (N_CSR > 0)     ? REG_CSR :
                                       (MEM_WORDS > 0) ? REG_MEM : REG_HDR;
    localparam logic [1:0] LAST_REG  = (MEM_WORDS > 0) ? REG_MEM :
                                       (N_CSR > 0)     ? REG_CSR :
                                       (N_GPR > 0)     ? REG_GPR : REG_HDR;
    localparam logic       ALL_EMPTY = (LAST_REG == REG_HDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_CAP,
        S_SEND
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   ts;
    logic [1:0]        region;
    logic [IDX_W-1:0]  idx;
    logic              pending;
    logic              per_fire;

    logic              trig_c;
    logic              hs_c;
    logic              done_c;
    logic              start_c;
    logic              busy_st_c;
    logic [1:0]        nxt_reg_c;
    logic [IDX_W-1:0]  nxt_idx_c;

    // Number of words in a region.
    function automatic logic [CNT_W-1:0] region_cnt(input logic [1:0] r);
        logic [CNT_W-1:0] n;
        case (r)
            REG_GPR: n = CNT_W'(N_GPR);
            REG_CSR: n = CNT_W'(N_CSR);
            REG_MEM: n = CNT_W'(MEM_WORDS);
            default: n = '0;
        endcase
        return n;
    endfunction

    // Next non-empty region after r, HDR when none remains.
    function automatic logic [1:0] next_region(input logic [1:0] r);
        logic [1:0] n;
        n = REG_HDR;
        if (r == REG_HDR && N_GPR > 0) begin
            n = REG_GPR;
        end else if (r <= REG_GPR && N_CSR > 0) begin
            n = REG_CSR;
        end else if (r <= REG_CSR && MEM_WORDS > 0) begin
            n = REG_MEM;
        end
        return n;
    endfunction

    // Read-port address: plain index for GPR/CSR, byte address for memory.
    function automatic logic [XLEN-1:0] addr_of(input logic [1:0] r, input logic [IDX_W-1:0] i);
        logic [XLEN-1:0] a;
        if (r == REG_MEM) begin
            a = XLEN'(MEM_BASE) + XLEN'(i) * XLEN'(STRIDE);
        end else begin
            a = XLEN'(i);
        end
        return a;
    endfunction

    // True for the final word of the final non-empty region.
    function automatic logic is_last(input logic [1:0] r, input logic [IDX_W-1:0] i);
        return (r == LAST_REG) && ((CNT_W'(i) + CNT_W'(1)) == region_cnt(r));
    endfunction

    // Periodic trigger: counter wraps every PERIOD_CYCLES clocks, fire is the wrap cycle.
    generate
        if (PERIOD_CYCLES > 0) begin : g_period
            localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
            logic [PW-1:0] pcnt;
            logic          fire_q;

            // Period counter and registered wrap pulse.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    pcnt   <= '0;
                    fire_q <= 1'b0;
                end else begin
                    fire_q <= (pcnt == PW'(PERIOD_CYCLES - 1));
                    if (pcnt == PW'(PERIOD_CYCLES - 1)) begin
                        pcnt <= '0;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
            end

            assign per_fire = fire_q;
        end else begin : g_no_period
            assign per_fire = 1'b0;
        end
    endgenerate

    // Trigger, handshake and next-word decode.
    always_comb begin
        trig_c    = i_trig | per_fire;
        hs_c      = o_dump_valid & i_dump_ready;
        done_c    = hs_c & o_dump_last;
        busy_st_c = (state != S_IDLE);
        start_c   = ((state == S_IDLE) & trig_c) | (done_c & (pending | trig_c));
        nxt_reg_c = region;
        nxt_idx_c = idx + IDX_W'(1);
        if ((CNT_W'(idx) + CNT_W'(1)) >= region_cnt(region)) begin
            nxt_reg_c = next_region(region);
            nxt_idx_c = '0;
        end
    end

    // Free-running timestamp.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + XLEN'(1);
        end
    end

    // One-deep pending request and saturating count of dropped triggers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending  <= 1'b0;
            o_missed <= '0;
        end else begin
            if (done_c) begin
                pending <= 1'b0;
            end else if (busy_st_c && trig_c) begin
                pending <= 1'b1;
            end
            if (busy_st_c && trig_c && pending && (o_missed != {MISS_W{1'b1}})) begin
                o_missed <= o_missed + MISS_W'(1);
            end
        end
    end

    // Dump sequencer: header, then read/capture/send per word across all regions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            region       <= REG_HDR;
            idx          <= '0;
            o_rd_en      <= 1'b0;
            o_rd_sel     <= '0;
            o_rd_addr    <= '0;
            o_dump_valid <= 1'b0;
            o_dump_data  <= '0;
            o_dump_tag   <= '0;
            o_dump_last  <= 1'b0;
            o_busy       <= 1'b0;
        end else if (start_c) begin
            // New dump: header carries the timestamp of the launching cycle.
            state        <= S_HDR;
            o_dump_valid <= 1'b1;
            o_dump_data  <= ts;
            o_dump_tag   <= '0;
            o_dump_last  <= ALL_EMPTY;
            o_busy       <= 1'b1;
        end else if (done_c) begin
            state        <= S_IDLE;
            o_dump_valid <= 1'b0;
            o_dump_last  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_busy <= 1'b0;
                end
                S_HDR: begin
                    if (hs_c) begin
                        state        <= S_RD;
                        o_dump_valid <= 1'b0;
                        region       <= FIRST_REG;
                        idx          <= '0;
                        o_rd_en      <= 1'b1;
                        o_rd_sel     <= FIRST_REG;
                        o_rd_addr    <= addr_of(FIRST_REG, '0);
                    end
                end
                S_RD: begin
                    state   <= S_CAP;
                    o_rd_en <= 1'b0;
                end
                S_CAP: begin
                    state        <= S_SEND;
                    o_dump_valid <= 1'b1;
                    o_dump_data  <= i_rd_data;
                    o_dump_tag   <= {region, idx};
                    o_dump_last  <= is_last(region, idx);
                end
                S_SEND: begin
                    if (hs_c) begin
                        state        <= S_RD;
                        o_dump_valid <= 1'b0;
                        region       <= nxt_reg_c;
                        idx          <= nxt_idx_c;
                        o_rd_en      <= 1'b1;
                        o_rd_sel     <= nxt_reg_c;
                        o_rd_addr    <= addr_of(nxt_reg_c, nxt_idx_c);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: a 32-bit instance with small CSR/memory
// windows and a 64-bit periodic instance with an empty CSR region.
module tb_state_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: XLEN=32, 32 GPR, 4 CSR, 4 memory words at 0x100, manual only.
    logic        rst_a_n, trig_a, rd_en_a, valid_a, ready_a, last_a, busy_a;
    logic [1:0]  rd_sel_a;
    logic [31:0] rd_addr_a, data_a;
    logic [31:0] rd_data_a = '0;
    logic [17:0] tag_a;
    logic [7:0]  missed_a;

    // Instance B: XLEN=64, 2 GPR, no CSR, 2 memory words at 0x200, period 500.
    logic        rst_b_n, trig_b, rd_en_b, valid_b, last_b, busy_b;
    logic        ready_b = 1'b1;
    logic [1:0]  rd_sel_b;
    logic [63:0] rd_addr_b, data_b;
    logic [63:0] rd_data_b = '0;
    logic [17:0] tag_b;
    logic [7:0]  missed_b;

    state_dump_unit #(
        .XLEN(32), .N_GPR(32), .N_CSR(4), .MEM_BASE(64'h100), .MEM_WORDS(4), .PERIOD_CYCLES(0)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_trig(trig_a),
        .o_rd_en(rd_en_a), .o_rd_sel(rd_sel_a), .o_rd_addr(rd_addr_a), .i_rd_data(rd_data_a),
        .o_dump_valid(valid_a), .i_dump_ready(ready_a), .o_dump_data(data_a),
        .o_dump_tag(tag_a), .o_dump_last(last_a), .o_busy(busy_a), .o_missed(missed_a)
    );

    state_dump_unit #(
        .XLEN(64), .N_GPR(2), .N_CSR(0), .MEM_BASE(64'h200), .MEM_WORDS(2), .PERIOD_CYCLES(500)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_trig(trig_b),
        .o_rd_en(rd_en_b), .o_rd_sel(rd_sel_b), .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b),
        .o_dump_valid(valid_b), .i_dump_ready(ready_b), .o_dump_data(data_b),
        .o_dump_tag(tag_b), .o_dump_last(last_b), .o_busy(busy_b), .o_missed(missed_b)
    );

    // Read-mux model: word encodes region and address so beats are self-identifying.
    function automatic logic [63:0] rd_model(input logic [1:0] sel, input logic [63:0] addr);
        return {32'hCAFEF00D, 4'hD, 2'b00, sel, 8'h00, addr[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= 32'(rd_model(rd_sel_a, 64'(rd_addr_a)));
        if (rd_en_b) rd_data_b <= rd_model(rd_sel_b, rd_addr_b);
    end

    // Bench cycle counters: clocks since reset release of each instance.
    int unsigned cyc_a, cyc_b;
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) cyc_a <= 0;
        else          cyc_a <= cyc_a + 1;
    end
    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) cyc_b <= 0;
        else          cyc_b <= cyc_b + 1;
    end

    typedef struct {
        logic [17:0] tag;
        logic [63:0] data;
        logic        last;
        int unsigned cyc;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    // Beat monitors: record every accepted beat with the cycle it was accepted in.
    always @(negedge clk) begin
        beat_t b;
        if (rst_a_n && valid_a && ready_a) begin
            b.tag = tag_a; b.data = 64'(data_a); b.last = last_a; b.cyc = cyc_a;
            qa.push_back(b);
        end
        if (rst_b_n && valid_b && ready_b) begin
            b.tag = tag_b; b.data = data_b; b.last = last_b; b.cyc = cyc_b;
            qb.push_back(b);
        end
    end

    // Expected {last, tag, data} of beat j in an instance-A dump.
    function automatic logic [82:0] exp_a(input int j, input logic [63:0] hts);
        logic [17:0] t;
        logic [63:0] d;
        if (j == 0) begin
            t = 18'h0; d = hts;
        end else if (j <= 32) begin
            t = {2'd1, 16'(j - 1)};  d = {32'h0, 32'(rd_model(2'd1, 64'(j - 1)))};
        end else if (j <= 36) begin
            t = {2'd2, 16'(j - 33)}; d = {32'h0, 32'(rd_model(2'd2, 64'(j - 33)))};
        end else begin
            t = {2'd3, 16'(j - 37)}; d = {32'h0, 32'(rd_model(2'd3, 64'(32'h100 + 4 * (j - 37))))};
        end
        return {(j == 40), t, d};
    endfunction

    // Expected {last, tag, data} of beat j in an instance-B dump.
    function automatic logic [82:0] exp_b(input int j, input logic [63:0] hts);
        logic [17:0] t;
        logic [63:0] d;
        if (j == 0) begin
            t = 18'h0; d = hts;
        end else if (j <= 2) begin
            t = {2'd1, 16'(j - 1)}; d = rd_model(2'd1, 64'(j - 1));
        end else begin
            t = {2'd3, 16'(j - 3)}; d = rd_model(2'd3, 64'(32'h200 + 8 * (j - 3)));
        end
        return {(j == 4), t, d};
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        trig_a  = 1'b0; trig_b  = 1'b0;
        ready_a = 1'b1;
        #1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) tick();

        // Reset state of both instances.
        check("rst_a_ctl", {rd_en_a, rd_sel_a, valid_a, last_a, busy_a, missed_a, tag_a}, '0);
        check("rst_a_dat", {rd_addr_a, data_a}, '0);
        check("rst_b_ctl", {rd_en_b, rd_sel_b, valid_b, last_b, busy_b, missed_b, tag_b}, '0);
        check("rst_b_dat", {rd_addr_b, data_b}, '0);

        rst_a_n = 1'b1;
        for (int n = 0; n < 50 && cyc_a != 10; n++) tick();
        check("cyc10", 128'(cyc_a), 128'd10);

        // Manual trigger in cycle 10: header carries timestamp 10.
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        check("hdr_beat", {busy_a, valid_a, last_a, tag_a, data_a}, {1'b1, 1'b1, 1'b0, 18'h0, 32'd10});

        // Backpressure on GPR 7 with two extra trigger pulses during the stall.
        for (int n = 0; n < 100 && !(valid_a && tag_a == 18'h10007); n++) tick();
        check("wait_gpr7", {valid_a, tag_a}, {1'b1, 18'h10007});
        ready_a = 1'b0;
        trig_a  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            trig_a = (i == 1);
            check("bp_hold", {valid_a, tag_a, data_a, last_a}, {1'b1, 18'h10007, 32'hD1000007, 1'b0});
        end
        trig_a  = 1'b0;
        ready_a = 1'b1;

        // Full first dump: 41 beats in order, last only on MEM 3.
        for (int n = 0; n < 300 && qa.size() < 41; n++) tick();
        check("dump1_len", 128'(qa.size() >= 41), 128'd1);
        if (qa.size() >= 41) begin
            for (int j = 0; j < 41; j++) begin
                check($sformatf("dump1_beat%0d", j), {qa[j].last, qa[j].tag, qa[j].data}, exp_a(j, 64'd10));
            end
        end
        check("missed_one", 128'(missed_a), 128'd1);

        // Pending dump starts right after the last handshake with that cycle's timestamp.
        for (int n = 0; n < 300 && qa.size() < 82; n++) tick();
        check("dump2_len", 128'(qa.size() >= 82), 128'd1);
        if (qa.size() >= 82) begin
            check("dump2_hdr_ts", qa[41].data, 128'(qa[40].cyc));
            check("dump2_b2b", 128'(qa[41].cyc), 128'(qa[40].cyc + 1));
            check("dump2_gpr0", {qa[42].last, qa[42].tag, qa[42].data}, exp_a(1, 64'd0));
            check("dump2_last", {qa[81].last, qa[81].tag, qa[81].data}, exp_a(40, qa[41].data));
        end
        for (int n = 0; n < 300 && busy_a; n++) tick();
        check("idle_after2", {busy_a, valid_a, rd_en_a}, 3'b000);

        // Held trigger while the sink stalls: one dump, one pending, the rest saturate.
        ready_a = 1'b0;
        trig_a  = 1'b1;
        repeat (300) tick();
        trig_a  = 1'b0;
        check("missed_sat", 128'(missed_a), 128'd255);
        check("hdr_stall", {valid_a, busy_a, tag_a}, {1'b1, 1'b1, 18'h0});
        ready_a = 1'b1;
        for (int n = 0; n < 600 && busy_a; n++) tick();
        check("sat_dumps", 128'(qa.size()), 128'd164);
        check("missed_hold", 128'(missed_a), 128'd255);

        // Reset in the middle of the CSR 2 beat aborts immediately.
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        for (int n = 0; n < 300 && !(valid_a && tag_a == 18'h20002); n++) tick();
        check("wait_csr2", {valid_a, tag_a}, {1'b1, 18'h20002});
        #2;
        rst_a_n = 1'b0;
        #1;
        check("rst_mid", {valid_a, busy_a, rd_en_a, last_a, missed_a}, '0);
        tick();
        qa.delete();
        tick();
        rst_a_n = 1'b1;
        repeat (3) tick();
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        for (int n = 0; n < 50 && qa.size() < 2; n++) tick();
        check("restart_len", 128'(qa.size() >= 2), 128'd1);
        if (qa.size() >= 2) begin
            check("restart_hdr", {qa[0].last, qa[0].tag, qa[0].data}, exp_a(0, 64'd3));
            check("restart_gpr0", {qa[1].last, qa[1].tag, qa[1].data}, exp_a(1, 64'd0));
        end

        // Periodic 64-bit instance with a manual pulse coinciding with the second fire.
        tick();
        rst_b_n = 1'b1;
        for (int n = 0; n < 1100 && cyc_b != 1000; n++) tick();
        check("cyc1000", 128'(cyc_b), 128'd1000);
        trig_b = 1'b1;
        tick();
        trig_b = 1'b0;
        for (int n = 0; n < 600 && cyc_b < 1520; n++) tick();
        check("per_len", 128'(qb.size()), 128'd15);
        if (qb.size() == 15) begin
            for (int d = 0; d < 3; d++) begin
                for (int j = 0; j < 5; j++) begin
                    check($sformatf("per_d%0d_b%0d", d, j), {qb[d * 5 + j].last, qb[d * 5 + j].tag, qb[d * 5 + j].data}, exp_b(j, 64'(500 * (d + 1))));
                end
            end
        end
        check("per_missed", 128'(missed_b), 128'd0);
        check("per_idle", {busy_b, valid_b}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
